// File: rtl/req_encoder_10to4.sv
// Ten-source event collector: sticky pending bits, round-robin arbitration and
// a valid/ready handshake presenting the 4-bit index of the granted source.
module req_encoder_10to4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       H,
  input  logic       I,
  input  logic       J,
  input  logic       ready,
  output logic       valid,
  output logic [3:0] sel,
  output logic       ovf,
  output logic [9:0] pend
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] pend_q, pend_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] last_q, last_d;
  logic       ovf_q, ovf_d;

  logic [9:0] strb;
  logic [9:0] clr;
  logic [9:0] cand;
  logic       accept;

  // First set bit of req scanning base+1, base+2, ... modulo 10.
  function automatic logic [3:0] rr_pick(input logic [9:0] req, input logic [3:0] base);
    logic [3:0] pick;
    logic [4:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 10; i++) begin
      idx = {1'b0, base} + 5'(i);
      if (idx >= 5'd10) idx = idx - 5'd10;
      if (!found && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      sel_q   <= '0;
      last_q  <= 4'd9;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    strb   = {J, I, H, G, F, E, D, C, B, A};
    accept = (state_q == GRANT) && ready;
    clr    = accept ? (10'd1 << sel_q) : '0;
    cand   = pend_q & ~clr;
    // New strobes are OR-ed after the clear so a same-edge hit on the accepted bit survives.
    pend_d = cand | strb;
    ovf_d  = |(strb & cand);

    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          sel_d   = rr_pick(pend_q, last_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ready) begin
          last_d = sel_q;
          if (|cand) sel_d = rr_pick(cand, sel_q);
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == GRANT);
    sel   = sel_q;
    ovf   = ovf_q;
    pend  = pend_q;
  end

endmodule

// File: tb/tb_req_encoder_10to4.sv
// Directed bench for req_encoder_10to4: direct output checks plus a queue of
// expected grant indices popped whenever a handshake completes.
module tb_req_encoder_10to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] strb;
  logic       ready;
  logic       valid;
  logic [3:0] sel;
  logic       ovf;
  logic [9:0] pend;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_sel;

  always #5 clk = ~clk;

  req_encoder_10to4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (strb[0]),
    .B     (strb[1]),
    .C     (strb[2]),
    .D     (strb[3]),
    .E     (strb[4]),
    .F     (strb[5]),
    .G     (strb[6]),
    .H     (strb[7]),
    .I     (strb[8]),
    .J     (strb[9]),
    .ready (ready),
    .valid (valid),
    .sel   (sel),
    .ovf   (ovf),
    .pend  (pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed handshake must match the next expected index.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed sel %0d expected no grant", sel);
      end
      if (exp_q.size() > 0) begin
        exp_sel = exp_q.pop_front();
        n_checks++;
        assert (sel === exp_sel)
        else begin
          n_fail++;
          $error("FAIL sb_sel: observed %0d expected %0d", sel, exp_sel);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    strb  = '0;
    ready = 1'b0;
    #2;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sel",   32'(sel),   32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_pend",  32'(pend),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Round robin with wrap from last=9: A, E, J
    strb = 10'b10_0001_0001;
    exp_q.push_back(4'd0); exp_q.push_back(4'd4); exp_q.push_back(4'd9);
    tick();
    strb = '0;
    chk("rr_pend", 32'(pend), 32'h211);
    chk("rr_valid0", 32'(valid), 32'd0);
    ready = 1'b1;
    tick(); chk("rr_sel0", 32'(sel), 32'd0); chk("rr_v0", 32'(valid), 32'd1);
    tick(); chk("rr_sel4", 32'(sel), 32'd4); chk("rr_v4", 32'(valid), 32'd1);
    tick(); chk("rr_sel9", 32'(sel), 32'd9); chk("rr_v9", 32'(valid), 32'd1);
    tick(); chk("rr_idle", 32'(valid), 32'd0); chk("rr_pend0", 32'(pend), 32'd0);

    // A and J again: pointer sits at 9
    strb = 10'b10_0000_0001;
    exp_q.push_back(4'd0); exp_q.push_back(4'd9);
    tick();
    strb = '0;
    chk("aj_pend", 32'(pend), 32'h201);
    tick(); chk("aj_sel0", 32'(sel), 32'd0);
    tick(); chk("aj_sel9", 32'(sel), 32'd9); chk("aj_v9", 32'(valid), 32'd1);
    tick(); chk("aj_idle", 32'(valid), 32'd0);
    ready = 1'b0;

    // Single strobe C
    strb = 10'b00_0000_0100;
    exp_q.push_back(4'd2);
    tick();
    strb = '0;
    chk("c_pend", 32'(pend), 32'h004);
    chk("c_valid0", 32'(valid), 32'd0);
    tick();
    chk("c_valid", 32'(valid), 32'd1);
    chk("c_sel", 32'(sel), 32'd2);
    ready = 1'b1;
    tick();
    chk("c_idle", 32'(valid), 32'd0);
    chk("c_pend0", 32'(pend), 32'd0);
    ready = 1'b0;

    // Stall hold on F while B arrives; afterwards B (index 1) follows
    strb = 10'b00_0010_0000;
    exp_q.push_back(4'd5); exp_q.push_back(4'd1);
    tick();
    strb = '0;
    tick();
    chk("st_sel", 32'(sel), 32'd5);
    strb = 10'b00_0000_0010;
    tick();
    strb = '0;
    chk("st_pend", 32'(pend), 32'h022);
    chk("st_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("st_hold_sel", 32'(sel), 32'd5);
      chk("st_hold_v", 32'(valid), 32'd1);
      if (k < 3) tick();
    end
    ready = 1'b1;
    tick();
    chk("st_next", 32'(sel), 32'd1);
    chk("st_next_v", 32'(valid), 32'd1);
    tick();
    chk("st_idle", 32'(valid), 32'd0);
    ready = 1'b0;

    // Overflow on pending D, then set-wins on the accepting edge
    strb = 10'b00_0000_1000;
    exp_q.push_back(4'd3); exp_q.push_back(4'd3);
    tick();
    strb = '0;
    tick();
    chk("ov_sel", 32'(sel), 32'd3);
    chk("ov_ovf0", 32'(ovf), 32'd0);
    strb = 10'b00_0000_1000;
    tick();
    strb = '0;
    chk("ov_pulse", 32'(ovf), 32'd1);
    chk("ov_pend", 32'(pend), 32'h008);
    tick();
    chk("ov_once", 32'(ovf), 32'd0);
    chk("ov_pend2", 32'(pend), 32'h008);
    ready = 1'b1;
    strb  = 10'b00_0000_1000;
    tick();
    strb = '0;
    chk("sw_pend", 32'(pend), 32'h008);
    chk("sw_ovf", 32'(ovf), 32'd0);
    chk("sw_valid", 32'(valid), 32'd0);
    tick();
    chk("sw_again_v", 32'(valid), 32'd1);
    chk("sw_again_sel", 32'(sel), 32'd3);
    tick();
    chk("sw_idle", 32'(valid), 32'd0);
    chk("sw_pend0", 32'(pend), 32'd0);
    ready = 1'b0;

    // Asynchronous reset with A, B, C pending and a grant up
    strb = 10'b00_0000_0111;
    tick();
    strb = '0;
    chk("ar_pend", 32'(pend), 32'h007);
    tick();
    chk("ar_valid", 32'(valid), 32'd1);
    chk("ar_sel", 32'(sel), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rvalid", 32'(valid), 32'd0);
    chk("ar_rsel", 32'(sel), 32'd0);
    chk("ar_rovf", 32'(ovf), 32'd0);
    chk("ar_rpend", 32'(pend), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ar_quiet", 32'(valid), 32'd0);
    end

    // All ten sources at once, ready held high
    ready = 1'b1;
    strb  = '1;
    for (int k = 0; k < 10; k++) exp_q.push_back(4'(k));
    tick();
    strb = '0;
    chk("all_pend", 32'(pend), 32'h3FF);
    chk("all_ovf0", 32'(ovf), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("all_sel", 32'(sel), 32'(k));
      chk("all_v", 32'(valid), 32'd1);
      chk("all_ovf", 32'(ovf), 32'd0);
    end
    tick();
    chk("all_idle", 32'(valid), 32'd0);
    chk("all_pend0", 32'(pend), 32'd0);
    ready = 1'b0;
    tick();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
